// File: rtl/resp_misr_checker_if.sv
// Response beat channel between the dut output capture and the MISR checker.
// Master drives vectors; slave reports when it can absorb one.
interface resp_misr_checker_if #(
  parameter int RESP_W = 40
);
  logic              resp_valid;
  logic [RESP_W-1:0] resp;
  logic              resp_ready;

  modport master (
    output resp_valid,
    output resp,
    input  resp_ready
  );

  modport slave (
    input  resp_valid,
    input  resp,
    output resp_ready
  );
endinterface

// File: rtl/resp_misr_checker.sv
// Compacts dut responses into a MISR over a programmed vector count
// and compares the final signature against a latched golden value.
module resp_misr_checker #(
  parameter int                RESP_W = 40,
  parameter int                CNT_W  = 16,
  parameter logic [RESP_W-1:0] POLY   = 40'h00_0000_0015,
  parameter logic [RESP_W-1:0] SEED   = 40'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    num_vec,
  input  logic [RESP_W-1:0]   golden,
  resp_misr_checker_if.slave  rsp,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [RESP_W-1:0]   signature,
  output logic [CNT_W-1:0]    vec_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [RESP_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [RESP_W-1:0] gold_q, gold_d;
  logic              pass_q, pass_d;

  logic [RESP_W-1:0] sig_nxt;
  logic [CNT_W-1:0]  cnt_inc;

  assign sig_nxt = {sig_q[RESP_W-2:0], 1'b0}
                 ^ (sig_q[RESP_W-1] ? POLY : '0)
                 ^ rsp.resp;
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    gold_d  = gold_q;
    pass_d  = pass_q;
    if (abort) begin
      // signature and count are kept for post-mortem inspection
      state_d = IDLE;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            num_d  = num_vec;
            gold_d = golden;
            sig_d  = SEED;
            cnt_d  = '0;
            pass_d = 1'b0;
            if (num_vec == '0) begin
              state_d = DONE;
              pass_d  = (SEED == golden);
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (rsp.resp_valid) begin
            sig_d = sig_nxt;
            cnt_d = cnt_inc;
            if (cnt_inc == num_q) begin
              state_d = DONE;
              pass_d  = (sig_nxt == gold_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      gold_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      gold_q  <= gold_d;
      pass_q  <= pass_d;
    end
  end

  assign rsp.resp_ready = (state_q == RUN);
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign signature      = sig_q;
  assign vec_count      = cnt_q;

endmodule
